// File: rtl/pipe_stage_buf.sv
//============================================================================
// Module      : pipe_stage_buf
// Description : Inter-stage pipeline register with valid/ready handshake,
//               optional two-entry skid buffer, flush and stall counter.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module pipe_stage_buf #(
    parameter int DATA_W = 64,
    parameter int SKID   = 1,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        occupancy_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] C_STALL_MAX = '1;

    state_t              r_state;
    logic [DATA_W-1:0]   r_main;
    logic [DATA_W-1:0]   r_skid;
    logic                r_out_valid;
    logic                r_in_ready;
    logic [CNT_W-1:0]    r_stall;

    logic                w_accept;
    logic                w_issue;

    // Registered ready only exists when the skid entry can absorb the
    // word already in flight; otherwise ready must look at downstream.
    generate
        if (SKID != 0) begin : g_skid
            assign in_ready_o = r_in_ready;
        end else begin : g_noskid
            assign in_ready_o = !r_out_valid | out_ready_i;
        end
    endgenerate

    assign w_accept    = in_valid_i & in_ready_o;
    assign w_issue     = r_out_valid & out_ready_i;
    assign out_valid_o = r_out_valid;
    assign out_data_o  = r_main;
    assign occupancy_o = r_state;
    assign stall_cnt_o = r_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_EMPTY;
            r_main      <= '0;
            r_skid      <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else if (flush_i) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_main      <= in_data_i;
                        r_state     <= ST_ONE;
                        r_out_valid <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_issue) begin
                        r_main <= in_data_i;
                    end else if (w_accept) begin
                        // Only reachable with SKID: no-skid ready implies issue here.
                        r_skid     <= in_data_i;
                        r_state    <= ST_FULL;
                        r_in_ready <= 1'b0;
                    end else if (w_issue) begin
                        r_state     <= ST_EMPTY;
                        r_out_valid <= 1'b0;
                    end
                end
                ST_FULL: begin
                    if (w_issue) begin
                        r_main     <= r_skid;
                        r_state    <= ST_ONE;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    // Back-pressure counter keeps counting through flushes; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall <= '0;
        end else if (r_out_valid && !out_ready_i && (r_stall != C_STALL_MAX)) begin
            r_stall <= r_stall + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_buf.sv
//============================================================================
// Module      : tb_pipe_stage_buf
// Description : Bench for pipe_stage_buf; three instances (skid, no-skid,
//               skid with 4-bit counter) checked against a FIFO model.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_pipe_stage_buf;

    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          flush     [3];
    logic          in_valid  [3];
    logic          in_ready  [3];
    logic [DW-1:0] in_data   [3];
    logic          out_valid [3];
    logic          out_ready [3];
    logic [DW-1:0] out_data  [3];
    logic [1:0]    occ       [3];
    logic [31:0]   stall     [3];
    logic [3:0]    stall_small;

    assign stall[2] = {28'd0, stall_small};

    pipe_stage_buf #(.DATA_W(DW), .SKID(1), .CNT_W(32)) u_skid (
        .clk(clk), .rst_n(rst_n), .flush_i(flush[0]),
        .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]), .in_data_i(in_data[0]),
        .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]), .out_data_o(out_data[0]),
        .occupancy_o(occ[0]), .stall_cnt_o(stall[0]));

    pipe_stage_buf #(.DATA_W(DW), .SKID(0), .CNT_W(32)) u_noskid (
        .clk(clk), .rst_n(rst_n), .flush_i(flush[1]),
        .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]), .in_data_i(in_data[1]),
        .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]), .out_data_o(out_data[1]),
        .occupancy_o(occ[1]), .stall_cnt_o(stall[1]));

    pipe_stage_buf #(.DATA_W(DW), .SKID(1), .CNT_W(4)) u_cnt4 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush[2]),
        .in_valid_i(in_valid[2]), .in_ready_o(in_ready[2]), .in_data_i(in_data[2]),
        .out_valid_o(out_valid[2]), .out_ready_i(out_ready[2]), .out_data_o(out_data[2]),
        .occupancy_o(occ[2]), .stall_cnt_o(stall_small));

    int nerr = 0;
    int nchk = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each stage is a FIFO of capacity 2 (skid) or 1 (no skid).
    logic [DW-1:0] mdat  [3][2];
    int            mcnt  [3];
    longint        mstall[3];

    function automatic bit is_skid(input int k);
        return (k != 1);
    endfunction

    function automatic longint cnt_max(input int k);
        return (k == 2) ? 64'd15 : 64'hFFFF_FFFF;
    endfunction

    function automatic logic exp_ready(input int k);
        if (is_skid(k)) return (mcnt[k] < 2);
        return (mcnt[k] == 0) || out_ready[k];
    endfunction

    initial begin
        for (int k = 0; k < 3; k++) begin
            mcnt[k] = 0; mstall[k] = 0; mdat[k][0] = '0; mdat[k][1] = '0;
        end
        forever begin
            @(posedge clk);
            for (int k = 0; k < 3; k++) begin
                if (!rst_n) begin
                    mcnt[k] = 0;
                    mstall[k] = 0;
                end else begin
                    bit acc, iss;
                    acc = in_valid[k] && exp_ready(k);
                    iss = (mcnt[k] > 0) && out_ready[k];
                    if ((mcnt[k] > 0) && !out_ready[k] && (mstall[k] < cnt_max(k)))
                        mstall[k]++;
                    if (flush[k]) begin
                        mcnt[k] = 0;
                    end else begin
                        if (iss) begin
                            mdat[k][0] = mdat[k][1];
                            mcnt[k]--;
                        end
                        if (acc) begin
                            mdat[k][mcnt[k]] = in_data[k];
                            mcnt[k]++;
                        end
                    end
                end
            end
        end
    end

    // Compare process: every falling edge while out of reset.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                for (int k = 0; k < 3; k++) begin
                    chk($sformatf("m%0d.out_valid", k), {63'd0, out_valid[k]}, {63'd0, (mcnt[k] > 0)});
                    chk($sformatf("m%0d.in_ready", k), {63'd0, in_ready[k]}, {63'd0, exp_ready(k)});
                    chk($sformatf("m%0d.occ", k), {62'd0, occ[k]}, 64'(mcnt[k]));
                    chk($sformatf("m%0d.stall", k), {32'd0, stall[k]}, 64'(mstall[k]));
                    if (mcnt[k] > 0)
                        chk($sformatf("m%0d.data", k), {48'd0, out_data[k]}, {48'd0, mdat[k][0]});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        for (int k = 0; k < 3; k++) begin
            flush[k] = 1'b0; in_valid[k] = 1'b0; in_data[k] = '0; out_ready[k] = 1'b0;
        end
    endtask

    initial begin
        idle_all();
        rst_n = 1'b0;
        tick();
        tick();
        for (int k = 0; k < 3; k++) begin
            chk("rst.out_valid", {63'd0, out_valid[k]}, 64'd0);
            chk("rst.out_data", {48'd0, out_data[k]}, 64'd0);
            chk("rst.in_ready", {63'd0, in_ready[k]}, 64'd1);
            chk("rst.occ", {62'd0, occ[k]}, 64'd0);
            chk("rst.stall", {32'd0, stall[k]}, 64'd0);
        end
        rst_n = 1'b1;
        tick();

        // Back-to-back stream with one-cycle latency
        out_ready[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid[0] = 1'b1;
            in_data[0]  = DW'(16'hA0 + i);
            tick();
            chk("t1.data", {48'd0, out_data[0]}, 64'(16'hA0 + i));
            chk("t1.valid", {63'd0, out_valid[0]}, 64'd1);
            chk("t1.ready", {63'd0, in_ready[0]}, 64'd1);
        end
        in_valid[0] = 1'b0;
        tick();
        chk("t1.drain", {63'd0, out_valid[0]}, 64'd0);

        // Skid fills under back-pressure, third word held upstream
        out_ready[0] = 1'b0;
        in_valid[0] = 1'b1; in_data[0] = 16'h11;
        tick();
        chk("t2.ready1", {63'd0, in_ready[0]}, 64'd1);
        in_data[0] = 16'h22;
        tick();
        chk("t2.ready0", {63'd0, in_ready[0]}, 64'd0);
        chk("t2.occ", {62'd0, occ[0]}, 64'd2);
        in_data[0] = 16'h33;
        tick();
        chk("t2.hold", {48'd0, out_data[0]}, 64'h11);
        chk("t2.held", {63'd0, in_ready[0]}, 64'd0);
        out_ready[0] = 1'b1;
        tick();
        chk("t2.out22", {48'd0, out_data[0]}, 64'h22);
        tick();
        chk("t2.out33", {48'd0, out_data[0]}, 64'h33);
        in_valid[0] = 1'b0;
        tick();
        chk("t2.empty", {63'd0, out_valid[0]}, 64'd0);

        // No-skid: ready follows downstream in the same cycle
        out_ready[1] = 1'b0;
        in_valid[1] = 1'b1; in_data[1] = 16'h55;
        tick();
        chk("t3.ready0", {63'd0, in_ready[1]}, 64'd0);
        in_data[1] = 16'h66;
        tick();
        chk("t3.hold", {48'd0, out_data[1]}, 64'h55);
        out_ready[1] = 1'b1;
        #1;
        chk("t3.ready1", {63'd0, in_ready[1]}, 64'd1);
        tick();
        chk("t3.out66", {48'd0, out_data[1]}, 64'h66);
        in_valid[1] = 1'b0;
        tick();
        chk("t3.empty", {63'd0, out_valid[1]}, 64'd0);

        // Flush from FULL and from ONE with a simultaneous accept
        out_ready[0] = 1'b0;
        in_valid[0] = 1'b1; in_data[0] = 16'h71;
        tick();
        in_data[0] = 16'h72;
        tick();
        chk("t4.full", {62'd0, occ[0]}, 64'd2);
        flush[0] = 1'b1; in_data[0] = 16'h73;
        tick();
        flush[0] = 1'b0; in_valid[0] = 1'b0;
        chk("t4.occ", {62'd0, occ[0]}, 64'd0);
        chk("t4.valid", {63'd0, out_valid[0]}, 64'd0);
        chk("t4.ready", {63'd0, in_ready[0]}, 64'd1);
        in_valid[0] = 1'b1; in_data[0] = 16'h81;
        tick();
        flush[0] = 1'b1; in_data[0] = 16'h82;
        tick();
        flush[0] = 1'b0; in_valid[0] = 1'b0; out_ready[0] = 1'b1;
        chk("t4.flush1", {63'd0, out_valid[0]}, 64'd0);
        tick();
        chk("t4.gone", {63'd0, out_valid[0]}, 64'd0);

        // Saturating stall counter, data stable
        out_ready[2] = 1'b0;
        in_valid[2] = 1'b1; in_data[2] = 16'h5A;
        tick();
        in_valid[2] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("t5.stable", {48'd0, out_data[2]}, 64'h5A);
        end
        chk("t5.sat", {32'd0, stall[2]}, 64'd15);
        out_ready[2] = 1'b1;
        tick();

        // Mixed traffic on all instances
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < 3; k++) begin
                in_valid[k]  = (i % 3) != 0;
                out_ready[k] = (i % 4) != 1;
                in_data[k]   = DW'(16'hC0 + i + 16 * k);
            end
            tick();
        end
        idle_all();
        out_ready[0] = 1'b0;

        // Asynchronous reset while FULL
        in_valid[0] = 1'b1; in_data[0] = 16'hE1;
        tick();
        in_data[0] = 16'hE2;
        tick();
        in_valid[0] = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6.valid", {63'd0, out_valid[0]}, 64'd0);
        chk("t6.data", {48'd0, out_data[0]}, 64'd0);
        chk("t6.stall", {32'd0, stall[0]}, 64'd0);
        chk("t6.occ", {62'd0, occ[0]}, 64'd0);
        chk("t6.ready", {63'd0, in_ready[0]}, 64'd1);
        tick();
        rst_n = 1'b1;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

`default_nettype wire
